// File: rtl/ctrl_pipe_unit_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, ALU op codes,
// the decoded control bundle and the per-stage control subsets.
// Optional build macro: RV32M_DECODE_EN (M-extension ALU op decode).
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'd51;
  localparam logic [6:0] OPC_I      = 7'd19;
  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_JAL    = 7'd111;
  localparam logic [6:0] OPC_JALR   = 7'd103;
  localparam logic [6:0] OPC_BRANCH = 7'd99;
  localparam logic [6:0] OPC_LUI    = 7'd55;
  localparam logic [6:0] OPC_AUIPC  = 7'd23;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam int CTRL_ALU_W = 3;

  localparam logic [CTRL_ALU_W-1:0] ALU_OP_RTYPE  = 3'd0;
  localparam logic [CTRL_ALU_W-1:0] ALU_OP_ITYPE  = 3'd1;
  localparam logic [CTRL_ALU_W-1:0] ALU_OP_LOAD   = 3'd2;
  localparam logic [CTRL_ALU_W-1:0] ALU_OP_STORE  = 3'd3;
  localparam logic [CTRL_ALU_W-1:0] ALU_OP_BRANCH = 3'd4;
  localparam logic [CTRL_ALU_W-1:0] ALU_OP_MULDIV = 3'd5;

  typedef struct packed {
    logic                  reg_write;
    logic                  is_imm;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  jump;
    logic                  branch;
    logic                  u_type;
    logic [CTRL_ALU_W-1:0] alu_op;
  } ctrl_bundle_t;

  // Only the fields still consumed downstream of EX are carried further.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// Combinational decoder: opcode/funct7 -> control bundle, source-register
// usage flags and the illegal-opcode flag.
// Optional build macro: RV32M_DECODE_EN selects MULDIV for R-type funct7=1.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]   i_opcode,
  input  logic [6:0]   i_funct7,
  output ctrl_bundle_t o_bundle,
  output logic         o_use_rs1,
  output logic         o_use_rs2,
  output logic         o_illegal
);

`ifdef RV32M_DECODE_EN
  logic w_muldiv;
  assign w_muldiv = (i_funct7 == FUNCT7_MULDIV);
`else
  logic [6:0] w_unused_funct7;
  assign w_unused_funct7 = i_funct7;
`endif

  // Opcode table lookup; unknown opcodes decode to a bubble and flag illegal.
  always_comb begin
    o_bundle  = CTRL_BUBBLE;
    o_use_rs1 = 1'b0;
    o_use_rs2 = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_R: begin
        o_bundle.reg_write = 1'b1;
        o_bundle.alu_op    = ALU_OP_RTYPE;
`ifdef RV32M_DECODE_EN
        if (w_muldiv) o_bundle.alu_op = ALU_OP_MULDIV;
`endif
        o_use_rs1 = 1'b1;
        o_use_rs2 = 1'b1;
      end
      OPC_I: begin
        o_bundle.reg_write = 1'b1;
        o_bundle.is_imm    = 1'b1;
        o_bundle.alu_op    = ALU_OP_ITYPE;
        o_use_rs1          = 1'b1;
      end
      OPC_LOAD: begin
        o_bundle.reg_write  = 1'b1;
        o_bundle.is_imm     = 1'b1;
        o_bundle.mem_read   = 1'b1;
        o_bundle.mem_to_reg = 1'b1;
        o_bundle.alu_op     = ALU_OP_LOAD;
        o_use_rs1           = 1'b1;
      end
      OPC_STORE: begin
        o_bundle.is_imm    = 1'b1;
        o_bundle.mem_write = 1'b1;
        o_bundle.alu_op    = ALU_OP_STORE;
        o_use_rs1          = 1'b1;
        o_use_rs2          = 1'b1;
      end
      OPC_JAL: begin
        o_bundle.reg_write = 1'b1;
        o_bundle.is_imm    = 1'b1;
        o_bundle.jump      = 1'b1;
        o_bundle.alu_op    = ALU_OP_RTYPE;
      end
      OPC_JALR: begin
        o_bundle.reg_write = 1'b1;
        o_bundle.is_imm    = 1'b1;
        o_bundle.jump      = 1'b1;
        o_bundle.alu_op    = ALU_OP_ITYPE;
        o_use_rs1          = 1'b1;
      end
      OPC_BRANCH: begin
        o_bundle.branch = 1'b1;
        o_bundle.alu_op = ALU_OP_BRANCH;
        o_use_rs1       = 1'b1;
        o_use_rs2       = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        o_bundle.reg_write = 1'b1;
        o_bundle.u_type    = 1'b1;
        o_bundle.alu_op    = ALU_OP_RTYPE;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Control pipeline for the 5-stage RV32 core: ID decode, ID/EX, EX/MEM and
// MEM/WB control registers, load-use bubble insertion, redirect flush and
// external freeze. Optional build macro: RV32M_DECODE_EN.
//
// Flow control: stall_ext freezes every register (highest priority);
// otherwise ex_redirect flushes ID/EX; otherwise hazard_stall=1 means IF/ID
// and PC must hold while ID/EX takes a bubble; otherwise ID advances.
// EX/MEM and MEM/WB advance on every cycle without stall_ext.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W        = 3,
  parameter int RADDR_W         = 5,
  parameter int LU_STALL_CYCLES = 1
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [31:0]         id_instr,
  input  logic                ex_redirect,
  input  logic                stall_ext,
  output logic                hazard_stall,
  output logic                id_illegal,
  output logic                ex_reg_write,
  output logic                ex_is_imm,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_jump,
  output logic                ex_branch,
  output logic                ex_u_type,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [RADDR_W-1:0]  ex_rd,
  output logic                mem_reg_write,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic                mem_mem_to_reg,
  output logic [RADDR_W-1:0]  mem_rd,
  output logic                wb_reg_write,
  output logic                wb_mem_to_reg,
  output logic [RADDR_W-1:0]  wb_rd,
  output logic [1:0]          dbg_lu_cnt
);

  // Counter reload leaves the detect cycle itself as the first bubble.
  localparam logic [1:0] LU_RELOAD = 2'(LU_STALL_CYCLES - 1);

  ctrl_bundle_t        w_dec;
  ctrl_bundle_t        w_id_bundle;
  logic                w_use_rs1;
  logic                w_use_rs2;
  logic                w_opc_illegal;
  logic [RADDR_W-1:0]  w_id_rd;
  logic [RADDR_W-1:0]  w_rs1;
  logic [RADDR_W-1:0]  w_rs2;
  logic                w_detect;
  logic                w_stall_req;
  logic [2:0]          w_unused_funct3;

  ctrl_bundle_t        r_ex;
  logic [RADDR_W-1:0]  r_ex_rd;
  mem_ctrl_t           r_mem;
  logic [RADDR_W-1:0]  r_mem_rd;
  wb_ctrl_t            r_wb;
  logic [RADDR_W-1:0]  r_wb_rd;
  logic [1:0]          r_lu_cnt;

  ctrl_decode u_decode (
    .i_opcode  (id_instr[6:0]),
    .i_funct7  (id_instr[31:25]),
    .o_bundle  (w_dec),
    .o_use_rs1 (w_use_rs1),
    .o_use_rs2 (w_use_rs2),
    .o_illegal (w_opc_illegal)
  );

  assign w_unused_funct3 = id_instr[14:12];

  // An empty or illegal ID slot becomes a full bubble, destination included.
  assign w_id_bundle = id_valid ? w_dec : CTRL_BUBBLE;
  assign w_id_rd     = (id_valid && !w_opc_illegal) ? RADDR_W'(id_instr[11:7]) : '0;
  assign w_rs1       = RADDR_W'(id_instr[19:15]);
  assign w_rs2       = RADDR_W'(id_instr[24:20]);
  assign id_illegal  = id_valid & w_opc_illegal;

  // Load in EX writing a register that the ID instruction actually reads.
  assign w_detect = r_ex.mem_read && (r_ex_rd != '0) && id_valid &&
                    ((w_use_rs1 && (w_rs1 == r_ex_rd)) ||
                     (w_use_rs2 && (w_rs2 == r_ex_rd)));

  assign w_stall_req  = w_detect || (r_lu_cnt != 2'd0);
  assign hazard_stall = w_stall_req && !ex_redirect;

  // Pipeline control registers: freeze, flush/bubble or advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex     <= CTRL_BUBBLE;
      r_ex_rd  <= '0;
      r_mem    <= '0;
      r_mem_rd <= '0;
      r_wb     <= '0;
      r_wb_rd  <= '0;
    end else if (!stall_ext) begin
      if (ex_redirect || w_stall_req) begin
        r_ex    <= CTRL_BUBBLE;
        r_ex_rd <= '0;
      end else begin
        r_ex    <= w_id_bundle;
        r_ex_rd <= w_id_rd;
      end
      r_mem.reg_write  <= r_ex.reg_write;
      r_mem.mem_read   <= r_ex.mem_read;
      r_mem.mem_write  <= r_ex.mem_write;
      r_mem.mem_to_reg <= r_ex.mem_to_reg;
      r_mem_rd         <= r_ex_rd;
      r_wb.reg_write   <= r_mem.reg_write;
      r_wb.mem_to_reg  <= r_mem.mem_to_reg;
      r_wb_rd          <= r_mem_rd;
    end
  end

  // Remaining-bubble counter: redirect clears it, detect reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_cnt <= 2'd0;
    end else if (!stall_ext) begin
      if (ex_redirect)             r_lu_cnt <= 2'd0;
      else if (r_lu_cnt != 2'd0)   r_lu_cnt <= r_lu_cnt - 2'd1;
      else if (w_detect)           r_lu_cnt <= LU_RELOAD;
    end
  end

  assign ex_reg_write   = r_ex.reg_write;
  assign ex_is_imm      = r_ex.is_imm;
  assign ex_mem_read    = r_ex.mem_read;
  assign ex_mem_write   = r_ex.mem_write;
  assign ex_mem_to_reg  = r_ex.mem_to_reg;
  assign ex_jump        = r_ex.jump;
  assign ex_branch      = r_ex.branch;
  assign ex_u_type      = r_ex.u_type;
  assign ex_alu_op      = ALU_OP_W'(r_ex.alu_op);
  assign ex_rd          = r_ex_rd;
  assign mem_reg_write  = r_mem.reg_write;
  assign mem_mem_read   = r_mem.mem_read;
  assign mem_mem_write  = r_mem.mem_write;
  assign mem_mem_to_reg = r_mem.mem_to_reg;
  assign mem_rd         = r_mem_rd;
  assign wb_reg_write   = r_wb.reg_write;
  assign wb_mem_to_reg  = r_wb.mem_to_reg;
  assign wb_rd          = r_wb_rd;
  assign dbg_lu_cnt     = r_lu_cnt;

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Pipelined control unit for the 5-stage RV32 core. Decodes the ID-stage instruction into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards and inserts a configurable number of bubbles. Handles branch/jump redirect flushes and a global external stall.

## Interface
- `ALU_OP_W`, default 3: ALU operation code width.
- `RADDR_W`, default 5: register address width.
- `LU_STALL_CYCLES`, default 1: bubbles per load-use hazard; legal range 1..3.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_instr` in 32: ID instruction. Fields used: opcode[6:0], rd[11:7], rs1[19:15], rs2[24:20], funct7[31:25].
- `ex_redirect` in 1: branch taken or jump resolved in EX this cycle.
- `stall_ext` in 1: global freeze, e.g. memory busy.
- `hazard_stall` out 1: hold PC and IF/ID this cycle.
- `id_illegal` out 1: `id_valid` is high and the opcode is not in the decode table.
- `ex_reg_write`, `ex_is_imm`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_jump`, `ex_branch`, `ex_u_type` out 1 each: EX control.
- `ex_alu_op` out ALU_OP_W: EX ALU operation.
- `ex_rd` out RADDR_W: EX destination register.
- `mem_reg_write`, `mem_mem_read`, `mem_mem_write`, `mem_mem_to_reg` out 1 each: MEM control.
- `mem_rd` out RADDR_W: MEM destination register.
- `wb_reg_write`, `wb_mem_to_reg` out 1 each: WB control.
- `wb_rd` out RADDR_W: WB destination register.

## Operation
- Decode table, fields (reg_write, is_imm, mem_read, mem_write, mem_to_reg, jump, branch, u_type, alu_op):
  - R (51): 1,0,0,0,0,0,0,0, op 0.
  - I (19): 1,1,0,0,0,0,0,0, op 1.
  - Load (3): 1,1,1,0,1,0,0,0, op 2.
  - Store (35): 0,1,0,1,0,0,0,0, op 3.
  - JAL (111): 1,1,0,0,0,1,0,0, op 0.
  - JALR (103): 1,1,0,0,0,1,0,0, op 1.
  - Branch (99): 0,0,0,0,0,0,1,0, op 4.
  - LUI (55) and AUIPC (23): 1,0,0,0,0,0,0,1, op 0.
  - Any other opcode: all fields 0, op 0. No latches.
- `id_valid`=0 forces the decoded bundle to a bubble (all zero).
- Register usage:
  - rs1 and rs2: R, Store, Branch.
  - rs1 only: I, Load, JALR.
  - None: JAL, LUI, AUIPC.
- Load-use detect is high when all of the following hold:
  - `ex_mem_read`=1 and `ex_rd`≠0.
  - `id_valid`=1.
  - `ex_rd` equals a used rs1 or rs2.
- Stall counter `lu_cnt`, 2 bits:
  - `hazard_stall` = detect OR (`lu_cnt`≠0).
  - On detect with `lu_cnt`=0, load `lu_cnt` with LU_STALL_CYCLES−1.
  - While `lu_cnt`≠0, decrement each advancing cycle.
  - Each `hazard_stall` cycle loads a bubble into ID/EX. EX/MEM and MEM/WB advance normally.
- Redirect: `ex_redirect`=1 loads a bubble into ID/EX and clears `lu_cnt` to 0. `hazard_stall` is masked to 0 that cycle. The redirecting instruction advances to MEM normally.
- Priority: `stall_ext` > `ex_redirect` > hazard > normal advance.
- `stall_ext`=1: every register and `lu_cnt` holds. `hazard_stall` and `id_illegal` still reflect the current state combinationally.
- rd of stores and branches is propagated as decoded, but their reg_write is 0.

## Timing
- Decode and `id_illegal` are combinational from `id_instr`.
- ID→EX, EX→MEM and MEM→WB each take one clock. A bundle reaches WB 3 advancing cycles after ID.
- `hazard_stall` is combinational from EX registers, `id_instr` and `lu_cnt`.
- Reset (async, `rst_n`=0): all ex_/mem_/wb_ outputs are 0, `lu_cnt`=0, and therefore `hazard_stall`=0.
- Reset mid-stall: the counter is cleared and the in-flight bubble state is discarded.
- Back-to-back loads each feeding the next instruction: each detect stalls independently once `lu_cnt` has reached 0.

## Configuration
- `RV32M_DECODE_EN`, when defined: opcode 51 with funct7=7'b0000001 decodes alu_op=5 (ALU_OP_MULDIV). Other fields are the same as R-type.
- When undefined: funct7 is ignored for opcode 51, and alu_op is 0.

## Structure
- Shared package `ctrl_pkg`:
  - Opcode localparams (OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LUI, OPC_AUIPC).
  - ALU_OP_* encodings 0..5.
  - Packed struct `ctrl_bundle_t`.
  - Constant `CTRL_BUBBLE`.
- Sub-module `ctrl_decode`: combinational opcode/funct7 → `ctrl_bundle_t`, rs1/rs2 usage flags, and the illegal flag.
- Top level contains the pipeline registers, hazard detect, `lu_cnt` and priority logic.

## Test plan
- Reset, then issue add x3,x1,x2. After 1 cycle: ex_reg_write=1, ex_alu_op=0, ex_rd=3. After 3 cycles: wb_reg_write=1, wb_rd=3.
- lw x5,0(x1) followed by add x6,x5,x2, LU_STALL_CYCLES=1: hazard_stall=1 for exactly 1 cycle. Next cycle the EX bundle is all zero, and the add then enters EX.
- Same sequence with LU_STALL_CYCLES=3: hazard_stall high for 3 consecutive cycles and 3 bubbles in EX.
- lw x0 followed by a dependent add x6,x0,x2: no stall. Load followed by lui x5: no stall.
- ex_redirect during a load-use stall: hazard_stall drops the same cycle, lu_cnt=0, and the next EX is a bubble.
- stall_ext held for 4 cycles mid-sequence: all outputs frozen, then normal resumption. Opcode 0x7F: id_illegal=1 and a bubble is decoded. With RV32M_DECODE_EN, mul decodes ex_alu_op=5.
